// File: rtl/serial_rx_pkg.sv
// -----------------------------------------------------------------------------
// serial_rx_pkg
//   Shared definitions for the serial link receiver: default payload width,
//   number of leading MSB repeats the transmitter sends, bit-counter width and
//   the receiver FSM state type. Kept in one place so the frame length is
//   defined once for both ends of the link.
// -----------------------------------------------------------------------------
package serial_rx_pkg;

  localparam int DATA_W_DEF    = 32;  // payload width in bits
  localparam int LEAD_BITS_DEF = 1;   // extra leading copies of the MSB per frame
  localparam int CNT_W_DEF     = 6;   // must hold DATA_W + LEAD_BITS + 1

  // Frame length in sclk cycles with data_enable high.
  function automatic int frame_len(input int data_w, input int lead_bits);
    return data_w + lead_bits;
  endfunction

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,  // after reset: wait for enable low before accepting a frame
    ST_IDLE  = 2'd1,  // between frames
    ST_SHIFT = 2'd2   // inside a frame, shifting sdi in
  } rx_state_e;

endpackage : serial_rx_pkg

// File: rtl/serial_rx.sv
// -----------------------------------------------------------------------------
// serial_rx
//   Receive end of the serial link. Deserialises sdi (MSB first) while
//   data_enable is high and presents the received word to the core through a
//   valid/ack handshake. Frames with the wrong bit count raise a one-cycle
//   frame_err pulse; a good frame that arrives while the previous word is
//   still unacknowledged is dropped and sets the sticky overrun flag.
//
// Ports
//   sclk        in   serial clock, all state on posedge
//   rst_n       in   asynchronous active-low reset
//   data_enable in   frame enable / chip select from the transmitter
//   sdi         in   serial data, MSB first
//   data_ack    in   core has consumed data_out
//   data_out    out  last good word, held until the next good frame loads
//   data_valid  out  data_out holds an unacknowledged word
//   frame_err   out  one-cycle pulse: frame ended with the wrong bit count
//   overrun     out  sticky: good frame arrived while data_valid was high
// -----------------------------------------------------------------------------
module serial_rx
  import serial_rx_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int LEAD_BITS = LEAD_BITS_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic              sclk,
  input  logic              rst_n,
  input  logic              data_enable,
  input  logic              sdi,
  input  logic              data_ack,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              frame_err,
  output logic              overrun
);

  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(frame_len(DATA_W, LEAD_BITS));
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  rx_state_e         state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] shreg;

  logic shift_en;    // sample sdi into the shift register this edge
  logic cnt_start;   // first bit of a frame: counter restarts at 1
  logic frame_end;   // enable dropped while in a frame
  logic frame_good;
  logic frame_bad;
  logic ack_take;    // ack only counts against a word that is actually pending

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) state <= ST_SYNC;
    else        state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // Next-state and control decode
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first; a missing branch
  // would otherwise infer a latch.
  always_comb begin
    state_next = state;
    shift_en   = 1'b0;
    cnt_start  = 1'b0;
    frame_end  = 1'b0;
    unique case (state)
      // A frame already in flight when reset released must not be received.
      ST_SYNC: begin
        if (!data_enable) state_next = ST_IDLE;
      end
      ST_IDLE: begin
        if (data_enable) begin
          state_next = ST_SHIFT;
          shift_en   = 1'b1;
          cnt_start  = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (data_enable) begin
          shift_en = 1'b1;
        end else begin
          state_next = ST_IDLE;
          frame_end  = 1'b1;
        end
      end
      default: state_next = ST_SYNC;
    endcase
  end

  // The counter holds the bits of this frame excluding the enable-low sample.
  assign frame_good = frame_end && (cnt == FRAME_CNT);
  assign frame_bad  = frame_end && (cnt != FRAME_CNT);
  assign ack_take   = data_ack && data_valid;

  // ---------------------------------------------------------------------------
  // Datapath: shift register, bit counter, output word and flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      shreg      <= '0;
      cnt        <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      // Only the last DATA_W bits survive, so the repeated MSB falls off the top.
      if (shift_en) shreg <= {shreg[DATA_W-2:0], sdi};

      // Saturate so an arbitrarily long frame can never alias to FRAME_CNT.
      if (cnt_start)                  cnt <= CNT_ONE;
      else if (shift_en && cnt != '1) cnt <= cnt + CNT_ONE;

      frame_err <= frame_bad;

      // An ack on the completing edge frees the slot before the new word lands.
      if (frame_good && (!data_valid || ack_take)) begin
        data_out   <= shreg;
        data_valid <= 1'b1;
      end else if (ack_take) begin
        data_valid <= 1'b0;
      end

      if (ack_take)                      overrun <= 1'b0;
      else if (frame_good && data_valid) overrun <= 1'b1;
    end
  end

endmodule : serial_rx
